// File: rtl/asm_mmio_pkg.sv
// ============================================================================
//  Package : asm_mmio_pkg
//  Shared encodings for the asm test-result MMIO responder.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package asm_mmio_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam logic [1:0] OFF_CTRL    = 2'd0;
    localparam logic [1:0] OFF_CYCLES  = 2'd1;
    localparam logic [1:0] OFF_RESULT  = 2'd2;
    localparam logic [1:0] OFF_WRCOUNT = 2'd3;

    localparam logic [31:0] DEFAULT_PASS_CODE = 32'h0000_00FF;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/asm_result_mmio.sv
// ============================================================================
//  Module  : asm_result_mmio
//  Store-side result endpoint for asm test programs: RUN->PASS/FAIL/TIMEOUT.
//  Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module asm_result_mmio
    import asm_mmio_pkg::*;
#(
    parameter logic [29:0] BASE_WADDR     = 30'h2000_0000,
    parameter logic [31:0] PASS_CODE      = DEFAULT_PASS_CODE,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic        re,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        done,
    output logic        pass,
    output logic [31:0] fail_code
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_cycles;
    logic [31:0] r_wrcount;
    logic [31:0] r_result;
    logic [31:0] r_fail_code;
    logic [31:0] r_rdata;
    logic [31:0] w_rd_mux;
    logic [29:0] w_rel;
    logic [1:0]  w_off;
    logic        w_clr;
    logic        w_wr_result;
    logic        w_capture;
    logic        w_timeout_edge;
    logic        w_done;
    logic        w_pass;

    // Offset from the window base; a wrapped subtraction also rejects
    // addresses below the base.
    assign w_rel          = addr - BASE_WADDR;
    assign hit            = (w_rel < 30'd4);
    assign w_off          = w_rel[1:0];
    assign w_clr          = we && hit && (w_off == OFF_CTRL) && wdata[0];
    assign w_wr_result    = we && hit && (w_off == OFF_RESULT);
    assign w_capture      = w_wr_result && (r_state == ST_RUN);
    assign w_timeout_edge = (TIMEOUT_CYCLES != 32'd0) &&
                            (r_cycles == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_clr) begin
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (w_wr_result) begin
                w_state_nxt = (wdata == PASS_CODE) ? ST_PASS : ST_FAIL;
            end else if (w_timeout_edge) begin
                w_state_nxt = ST_TIMEOUT;
            end
        end
    end

    always_comb begin
        w_done = (r_state != ST_RUN);
        w_pass = (r_state == ST_PASS);
    end

    always_ff @(posedge clk) begin
        if (!rst || w_clr) begin
            r_cycles  <= '0;
            r_wrcount <= '0;
        end else begin
            if (r_state == ST_RUN) begin
                r_cycles <= sat_inc(r_cycles);
            end
            if (w_wr_result) begin
                r_wrcount <= sat_inc(r_wrcount);
            end
        end
    end

    // Only the first RESULT store after a clear is captured.
    always_ff @(posedge clk) begin
        if (!rst || w_clr) begin
            r_result    <= '0;
            r_fail_code <= '0;
        end else if (w_capture) begin
            r_result <= wdata;
            if (wdata != PASS_CODE) begin
                r_fail_code <= wdata;
            end
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            OFF_CTRL:    w_rd_mux = {28'd0, r_state, w_pass, w_done};
            OFF_CYCLES:  w_rd_mux = r_cycles;
            OFF_RESULT:  w_rd_mux = r_result;
            OFF_WRCOUNT: w_rd_mux = r_wrcount;
            default:     w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= (re && hit) ? w_rd_mux : '0;
        end
    end

    assign rdata     = r_rdata;
    assign done      = w_done;
    assign pass      = w_pass;
    assign fail_code = r_fail_code;

endmodule

`default_nettype wire
